mmc_blk_wr: RTL and testbench

Block-write sequencer for the MMC data lines: frames one data block as start bit, BLK_BYTES payload bytes, CRC16 and end bit, then collects the card's CRC status token and, optionally, waits out card busy. It sits between the transmit byte FIFO and the byte serializer (1-bit/4-bit data-line advance), and drives the data-line mux and MMC clock-tick request for all non-payload bit times. Issued by the command layer after a WRITE_BLOCK response; reports completion and error flags back to it.

---
 rtl/mmc_blk_wr_if.sv | 19 +
 rtl/mmc_blk_wr.sv | 234 +++++++++++++++++++++++
 tb/tb_mmc_blk_wr.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mmc_blk_wr_if.sv
// rtl/mmc_blk_wr_if.sv - byte path between TX FIFO, block-write sequencer and serializer
interface mmc_blk_wr_if;
    logic       fifo_empty;
    logic [7:0] fifo_dat;
    logic       fifo_rd;
    logic       adv_req;
    logic [7:0] adv_dat;
    logic       adv_ack;

    modport master (
        input  fifo_empty, fifo_dat, adv_ack,
        output fifo_rd, adv_req, adv_dat
    );

    modport slave (
        output fifo_empty, fifo_dat, adv_ack,
        input  fifo_rd, adv_req, adv_dat
    );
endinterface

// File: rtl/mmc_blk_wr.sv
// rtl/mmc_blk_wr.sv - MMC block-write sequencer; MMC_BLK_WR_BUSY_EN enables the card-busy wait
module mmc_blk_wr #(
    parameter int BLK_BYTES = 512,
    parameter int STAT_TO   = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         data_width,
    input  logic         start,
    input  logic         abort,
    mmc_blk_wr_if.master bus,
    output logic         bit_tick,
    input  logic         bit_ack,
    output logic         crc_clr,
    output logic         crc_shift,
    input  logic [3:0]   crc_bit,
    input  logic [3:0]   dat_in,
    output logic         dat_oe,
    output logic         dat_sel,
    output logic [3:0]   dat_out,
    output logic         done,
    output logic [2:0]   status,
    output logic         err_crc,
    output logic         err_to,
    output logic         err_abt
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_CRC, S_END, S_STAT, S_BUSY, S_DONE
    } state_t;

    localparam logic [11:0] CNT_LAST = 12'(BLK_BYTES - 1);
    localparam logic [15:0] TO_LAST  = 16'(STAT_TO - 1);

    state_t      state_q, state_d;
    logic        wide_q, wide_d;
    logic [11:0] cnt_q, cnt_d;
    logic        outst_q, outst_d;
    logic        req_q, req_d;
    logic [7:0]  adv_dat_q, adv_dat_d;
    logic [15:0] bcnt_q, bcnt_d;
    logic [1:0]  sph_q, sph_d;
    logic [2:0]  status_q, status_d;
    logic        err_crc_q, err_crc_d;
    logic        err_to_q, err_to_d;
    logic        err_abt_q, err_abt_d;
    logic        crc_clr_q, crc_clr_d;
    logic        fifo_rd_c;
    logic        unused_dat;

    // Only DAT0 carries the status token and busy indication
    assign unused_dat = ^dat_in[3:1];

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wide_q    <= 1'b0;
            cnt_q     <= '0;
            outst_q   <= 1'b0;
            req_q     <= 1'b0;
            adv_dat_q <= '0;
            bcnt_q    <= '0;
            sph_q     <= '0;
            status_q  <= '0;
            err_crc_q <= 1'b0;
            err_to_q  <= 1'b0;
            err_abt_q <= 1'b0;
            crc_clr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wide_q    <= wide_d;
            cnt_q     <= cnt_d;
            outst_q   <= outst_d;
            req_q     <= req_d;
            adv_dat_q <= adv_dat_d;
            bcnt_q    <= bcnt_d;
            sph_q     <= sph_d;
            status_q  <= status_d;
            err_crc_q <= err_crc_d;
            err_to_q  <= err_to_d;
            err_abt_q <= err_abt_d;
            crc_clr_q <= crc_clr_d;
        end
    end

    // Next-state, line control and FIFO/serializer handshake decode
    always_comb begin
        state_d   = state_q;
        wide_d    = wide_q;
        cnt_d     = cnt_q;
        outst_d   = outst_q;
        req_d     = 1'b0;
        adv_dat_d = adv_dat_q;
        bcnt_d    = bcnt_q;
        sph_d     = sph_q;
        status_d  = status_q;
        err_crc_d = err_crc_q;
        err_to_d  = err_to_q;
        err_abt_d = err_abt_q;
        crc_clr_d = 1'b0;
        fifo_rd_c = 1'b0;
        bit_tick  = 1'b0;
        crc_shift = 1'b0;
        dat_oe    = 1'b0;
        dat_sel   = 1'b0;
        dat_out   = 4'b0000;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d   = S_START;
                    wide_d    = data_width;
                    cnt_d     = '0;
                    outst_d   = 1'b0;
                    bcnt_d    = '0;
                    sph_d     = '0;
                    status_d  = '0;
                    err_crc_d = 1'b0;
                    err_to_d  = 1'b0;
                    err_abt_d = 1'b0;
                    crc_clr_d = 1'b1;
                end
            end
            S_START: begin
                dat_oe   = 1'b1;
                dat_out  = wide_q ? 4'b0000 : 4'b1110;
                bit_tick = 1'b1;
                if (bit_ack) state_d = S_DATA;
            end
            S_DATA: begin
                dat_oe  = 1'b1;
                dat_sel = 1'b1;
                // The ack of a byte is not trusted in its own request cycle
                if (outst_q && !req_q && bus.adv_ack) begin
                    outst_d = 1'b0;
                    cnt_d   = cnt_q + 12'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_CRC;
                        bcnt_d  = '0;
                    end
                end else if (!outst_q && !bus.fifo_empty) begin
                    fifo_rd_c = 1'b1;
                    adv_dat_d = bus.fifo_dat;
                    outst_d   = 1'b1;
                    req_d     = 1'b1;
                end
            end
            S_CRC: begin
                dat_oe    = 1'b1;
                dat_out   = wide_q ? crc_bit : {3'b111, crc_bit[0]};
                bit_tick  = 1'b1;
                crc_shift = bit_ack;
                if (bit_ack) begin
                    bcnt_d = bcnt_q + 16'd1;
                    if (bcnt_q == 16'd15) state_d = S_END;
                end
            end
            S_END: begin
                dat_oe   = 1'b1;
                dat_out  = 4'b1111;
                bit_tick = 1'b1;
                if (bit_ack) begin
                    state_d = S_STAT;
                    bcnt_d  = '0;
                    sph_d   = '0;
                end
            end
            S_STAT: begin
                bit_tick = 1'b1;
                if (bit_ack) begin
                    case (sph_q)
                        2'd0: begin
                            if (!dat_in[0]) begin
                                sph_d  = 2'd1;
                                bcnt_d = '0;
                            end else if (bcnt_q == TO_LAST) begin
                                err_to_d = 1'b1;
                                state_d  = S_DONE;
                            end else begin
                                bcnt_d = bcnt_q + 16'd1;
                            end
                        end
                        2'd1: begin
                            status_d = {status_q[1:0], dat_in[0]};
                            bcnt_d   = bcnt_q + 16'd1;
                            if (bcnt_q == 16'd2) sph_d = 2'd2;
                        end
                        default: begin
                            err_crc_d = (status_q != 3'b010);
`ifdef MMC_BLK_WR_BUSY_EN
                            state_d   = S_BUSY;
`else
                            state_d   = S_DONE;
`endif
                        end
                    endcase
                end
            end
`ifdef MMC_BLK_WR_BUSY_EN
            S_BUSY: begin
                bit_tick = 1'b1;
                if (bit_ack && dat_in[0]) state_d = S_DONE;
            end
`endif
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over any in-flight transfer and drops the FIFO pop
        if (abort && state_q != S_IDLE && state_q != S_DONE) begin
            state_d   = S_DONE;
            err_abt_d = 1'b1;
            outst_d   = 1'b0;
            req_d     = 1'b0;
            fifo_rd_c = 1'b0;
            adv_dat_d = adv_dat_q;
        end
    end

    assign bus.fifo_rd = fifo_rd_c;
    assign bus.adv_req = req_q;
    assign bus.adv_dat = adv_dat_q;
    assign crc_clr     = crc_clr_q;
    assign status      = status_q;
    assign err_crc     = err_crc_q;
    assign err_to      = err_to_q;
    assign err_abt     = err_abt_q;

endmodule

// File: tb/tb_mmc_blk_wr.sv
// tb/tb_mmc_blk_wr.sv - randomized scoreboard bench for mmc_blk_wr
module tb_mmc_blk_wr;
    localparam int BLK = 4;
    localparam int STO = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       data_width, start, abort, bit_ack;
    logic [3:0] crc_bit, dat_in;
    logic       bit_tick, crc_clr, crc_shift, dat_oe, dat_sel, done;
    logic [3:0] dat_out;
    logic [2:0] status;
    logic       err_crc, err_to, err_abt;

    always #5 clk = ~clk;

    mmc_blk_wr_if bif();

    mmc_blk_wr #(.BLK_BYTES(BLK), .STAT_TO(STO)) dut (
        .clk(clk), .rst_n(rst_n), .data_width(data_width), .start(start), .abort(abort),
        .bus(bif.master), .bit_tick(bit_tick), .bit_ack(bit_ack), .crc_clr(crc_clr),
        .crc_shift(crc_shift), .crc_bit(crc_bit), .dat_in(dat_in), .dat_oe(dat_oe),
        .dat_sel(dat_sel), .dat_out(dat_out), .done(done), .status(status),
        .err_crc(err_crc), .err_to(err_to), .err_abt(err_abt)
    );

    typedef struct {
        logic [2:0] status;
        logic       e_crc;
        logic       e_to;
        logic       e_abt;
        logic       chk_cnt;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_bytes[$];
    logic       card_q[$];
    logic [7:0] bytes_v[BLK];

    int checks = 0, errors = 0, cyc = 0;
    int rd_cnt, req_cnt, shift_cnt, ack_idx, endbit_idx, endbit_cyc, busy_len, gap_cnt, ser_wait;
    bit pop_pend, ser_busy, chk_start, chk_end, done_seen, cur_wide;
    logic [7:0] ser_byte;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // FIFO, serializer, MMC bit clock and card models plus the output monitor
    always @(negedge clk) begin
        cyc++;
        bit_ack = 1'b0;
        bif.adv_ack = 1'b0;
        if (rst_n) begin
            if (pop_pend) begin fifo_q.delete(0); pop_pend = 0; end
            if (gap_cnt > 0) gap_cnt--;
            bif.fifo_empty = (fifo_q.size() == 0) || (gap_cnt > 0);
            bif.fifo_dat = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
            if (ser_busy) begin
                ser_wait--;
                if (ser_wait == 0) begin
                    bif.adv_ack = 1'b1;
                    ser_busy = 0;
                    check("adv_dat_hold", 32'(bif.adv_dat), 32'(ser_byte));
                end
            end
            dat_in = 4'hF;
            crc_bit = 4'($urandom);
            if (bit_tick && $urandom_range(0, 1) == 1) begin
                bit_ack = 1'b1;
                if (!dat_oe) begin
                    if (card_q.size() != 0) dat_in[0] = card_q.pop_front();
                    if (ack_idx == endbit_idx) endbit_cyc = cyc;
                    ack_idx++;
                end
            end
        end
        #1;
        if (rst_n) begin
            if (bif.fifo_rd) begin
                check("fifo_rd_nonempty", 32'(bif.fifo_empty), 32'd0);
                pop_pend = 1;
                rd_cnt++;
            end
            if (gap_cnt > 0) check("gap_no_adv_req", 32'(bif.adv_req), 32'd0);
            if (bif.adv_req) begin
                req_cnt++;
                if (exp_bytes.size() == 0) check("adv_req_extra", 32'd1, 32'd0);
                else check("adv_dat", 32'(bif.adv_dat), 32'(exp_bytes.pop_front()));
                ser_busy = 1;
                ser_wait = $urandom_range(1, 4);
                ser_byte = bif.adv_dat;
            end
            if (crc_shift) begin
                check("crc_dat_out", 32'(dat_out), cur_wide ? 32'(crc_bit) : 32'({3'b111, crc_bit[0]}));
                shift_cnt++;
            end
            if (chk_start && dat_oe) begin
                check("start_dat_out", 32'(dat_out), cur_wide ? 32'h0 : 32'hE);
                check("crc_clr", 32'(crc_clr), 32'd1);
                chk_start = 0;
            end
            if (chk_end && shift_cnt == 16 && !crc_shift && dat_oe) begin
                check("end_dat_out", 32'(dat_out), 32'hF);
                chk_end = 0;
            end
            if (done) begin
                done_seen = 1;
                if (exp_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("status", 32'(status), 32'(e.status));
                    check("err_crc", 32'(err_crc), 32'(e.e_crc));
                    check("err_to", 32'(err_to), 32'(e.e_to));
                    check("err_abt", 32'(err_abt), 32'(e.e_abt));
                    if (e.chk_cnt) begin
                        check("fifo_rd_count", 32'(rd_cnt), 32'(BLK));
                        check("adv_req_count", 32'(req_cnt), 32'(BLK));
                        check("crc_shift_count", 32'(shift_cnt), 32'd16);
                        if (!e.e_to) begin
`ifdef MMC_BLK_WR_BUSY_EN
                            check("busy_acks", 32'(ack_idx), 32'(endbit_idx + busy_len + 2));
`else
                            check("done_after_end_bit", 32'(cyc - endbit_cyc), 32'd1);
`endif
                        end
                    end
                end
            end
        end
    end

    // mode 0: normal block, 1: will be aborted, 2: will be reset (no completion expected)
    task automatic load_block(input bit wide, input logic [2:0] st, input int k, input int busy_n, input int mode);
        exp_t x;
        @(negedge clk);
        card_q.delete();
        for (int i = 0; i < k; i++) card_q.push_back(1'b1);
        card_q.push_back(1'b0);
        for (int i = 2; i >= 0; i--) card_q.push_back(st[i]);
        card_q.push_back(1'b1);
        for (int i = 0; i < busy_n; i++) card_q.push_back(1'b0);
        if (mode == 1) begin
            x.status = 3'b000; x.e_crc = 0; x.e_to = 0; x.e_abt = 1; x.chk_cnt = 0;
        end else if (k >= STO) begin
            x.status = 3'b000; x.e_crc = 0; x.e_to = 1; x.e_abt = 0; x.chk_cnt = 1;
        end else begin
            x.status = st; x.e_crc = (st != 3'b010); x.e_to = 0; x.e_abt = 0; x.chk_cnt = 1;
        end
        if (mode != 2) exp_q.push_back(x);
        endbit_idx = (k >= STO) ? -1 : k + 4;
        busy_len = busy_n;
        ack_idx = 0; rd_cnt = 0; req_cnt = 0; shift_cnt = 0;
        for (int i = 0; i < BLK; i++) begin
            fifo_q.push_back(bytes_v[i]);
            exp_bytes.push_back(bytes_v[i]);
        end
        cur_wide = wide; chk_start = 1; chk_end = 1; done_seen = 0;
        data_width = wide; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        data_width = 1'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done_seen && n < 3000) begin @(negedge clk); #2; n++; end
        check("done_seen", 32'(done_seen), 32'd1);
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_req(input int target);
        int n = 0;
        while (req_cnt < target && n < 2000) begin @(negedge clk); #2; n++; end
        check("reached_byte", 32'(req_cnt >= target), 32'd1);
    endtask

    initial begin
        int n;
        start = 0; abort = 0; data_width = 0; bit_ack = 0; crc_bit = 0; dat_in = 4'hF;
        bif.fifo_empty = 1'b1; bif.fifo_dat = 8'h00; bif.adv_ack = 1'b0;
        gap_cnt = 0; pop_pend = 0; ser_busy = 0; chk_start = 0; chk_end = 0;
        endbit_idx = -1; endbit_cyc = 0; ack_idx = 0;
        repeat (3) @(negedge clk);
        #1 check("reset_outputs", 32'({bif.fifo_rd, bif.adv_req, bif.adv_dat, bit_tick, crc_clr, crc_shift,
                 dat_oe, dat_sel, dat_out, done, status, err_crc, err_to, err_abt}), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // start coincident with abort in IDLE is dropped
        @(negedge clk); start = 1; abort = 1;
        @(negedge clk); start = 0; abort = 0; #2;
        check("start_abort_ignored", 32'({dat_oe, bit_tick, crc_clr}), 32'd0);

        bytes_v = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        load_block(1, 3'b010, $urandom_range(0, 3), 3, 0); wait_done();
        load_block(0, 3'b101, $urandom_range(0, 3), 2, 0); wait_done();

        // FIFO runs dry for 20 cycles after the second byte
        load_block(1, 3'b010, 1, 1, 0);
        wait_req(2);
        gap_cnt = 21;
        wait_done();

        load_block(1, 3'b010, STO, 0, 0); wait_done();
        load_block(0, 3'b011, STO - 1, 0, 0); wait_done();

        // abort in the middle of the CRC field
        load_block(1, 3'b010, 0, 0, 1);
        n = 0;
        while (shift_cnt < 5 && n < 2000) begin @(negedge clk); #2; n++; end
        check("abort_in_crc", 32'(shift_cnt >= 5 && shift_cnt < 16), 32'd1);
        @(negedge clk); abort = 1;
        @(negedge clk); abort = 0; #2;
        check("abort_dat_oe", 32'(dat_oe), 32'd0);
        check("abort_bit_tick", 32'(bit_tick), 32'd0);
        check("abort_done", 32'(done), 32'd1);
        wait_done();
        load_block(0, 3'b010, 2, 1, 0); wait_done();

        // asynchronous reset in the middle of the payload
        for (int i = 0; i < BLK; i++) bytes_v[i] = 8'($urandom);
        load_block(1, 3'b010, 0, 0, 2);
        wait_req(2);
        @(negedge clk); #3; rst_n = 1'b0; #1;
        check("midblock_reset_outputs", 32'({bif.fifo_rd, bif.adv_req, bif.adv_dat, bit_tick, crc_clr, crc_shift,
              dat_oe, dat_sel, dat_out, done, status, err_crc, err_to, err_abt}), 32'd0);
        fifo_q.delete(); exp_bytes.delete(); card_q.delete();
        pop_pend = 0; ser_busy = 0; gap_cnt = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        #2 check("no_done_after_reset", 32'(done_seen), 32'd0);

        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < BLK; i++) bytes_v[i] = 8'($urandom);
            load_block(1'($urandom), 3'($urandom), $urandom_range(0, STO), $urandom_range(0, 3), 0);
            wait_done();
        end

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
